// File: rtl/instr_fetch_decode_pkg.sv
// Shared definitions for the instruction fetch/decode slice.
// Holds the MIPS opcode and funct encodings, the bit position of every
// operation inside the 31-bit one-hot code vector, the fetch FSM state
// enum and a helper that turns a bit index into a one-hot code word.
package instr_fetch_decode_pkg;

    localparam int unsigned CODE_W = 31;

    // Primary opcode field values (instr[31:26])
    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_J       = 6'h02;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_BNE     = 6'h05;
    localparam logic [5:0] OP_ADDI    = 6'h08;
    localparam logic [5:0] OP_ADDIU   = 6'h09;
    localparam logic [5:0] OP_SLTI    = 6'h0A;
    localparam logic [5:0] OP_SLTIU   = 6'h0B;
    localparam logic [5:0] OP_ANDI    = 6'h0C;
    localparam logic [5:0] OP_ORI     = 6'h0D;
    localparam logic [5:0] OP_XORI    = 6'h0E;
    localparam logic [5:0] OP_LUI     = 6'h0F;
    localparam logic [5:0] OP_LW      = 6'h23;
    localparam logic [5:0] OP_SW      = 6'h2B;

    // Function field values for OP_SPECIAL (instr[5:0])
    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_SLLV = 6'h04;
    localparam logic [5:0] FN_SRLV = 6'h06;
    localparam logic [5:0] FN_SRAV = 6'h07;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    // Bit positions inside the one-hot code vector
    localparam logic [4:0] IDX_ADD   = 5'd0;
    localparam logic [4:0] IDX_ADDU  = 5'd1;
    localparam logic [4:0] IDX_SUB   = 5'd2;
    localparam logic [4:0] IDX_SUBU  = 5'd3;
    localparam logic [4:0] IDX_AND   = 5'd4;
    localparam logic [4:0] IDX_OR    = 5'd5;
    localparam logic [4:0] IDX_XOR   = 5'd6;
    localparam logic [4:0] IDX_NOR   = 5'd7;
    localparam logic [4:0] IDX_SLT   = 5'd8;
    localparam logic [4:0] IDX_SLTU  = 5'd9;
    localparam logic [4:0] IDX_SLL   = 5'd10;
    localparam logic [4:0] IDX_SRL   = 5'd11;
    localparam logic [4:0] IDX_SRA   = 5'd12;
    localparam logic [4:0] IDX_SLLV  = 5'd13;
    localparam logic [4:0] IDX_SRLV  = 5'd14;
    localparam logic [4:0] IDX_SRAV  = 5'd15;
    localparam logic [4:0] IDX_JR    = 5'd16;
    localparam logic [4:0] IDX_ADDI  = 5'd17;
    localparam logic [4:0] IDX_ADDIU = 5'd18;
    localparam logic [4:0] IDX_ANDI  = 5'd19;
    localparam logic [4:0] IDX_ORI   = 5'd20;
    localparam logic [4:0] IDX_XORI  = 5'd21;
    localparam logic [4:0] IDX_LW    = 5'd22;
    localparam logic [4:0] IDX_SW    = 5'd23;
    localparam logic [4:0] IDX_BEQ   = 5'd24;
    localparam logic [4:0] IDX_BNE   = 5'd25;
    localparam logic [4:0] IDX_SLTI  = 5'd26;
    localparam logic [4:0] IDX_SLTIU = 5'd27;
    localparam logic [4:0] IDX_LUI   = 5'd28;
    localparam logic [4:0] IDX_J     = 5'd29;
    localparam logic [4:0] IDX_JAL   = 5'd30;

    // Fetch sequencer states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } fsm_state_e;

    // One-hot code word with only bit idx set
    function automatic logic [CODE_W-1:0] onehot_code(input logic [4:0] idx);
        onehot_code = 31'd1 << idx;
    endfunction

endpackage

// File: rtl/instr_fetch_decode_rom.sv
// Combinational decode table for the fetch/decode slice.
// Ports:
//   instr   (in, 32)  raw instruction word
//   code    (out, 31) one-hot operation vector, all zero when unmatched
//   illegal (out, 1)  high when the encoding matches no known operation
// R-type words (opcode 0) are decoded on funct; everything else on opcode.
module instr_decode_rom
    import instr_fetch_decode_pkg::*;
(
    input  logic [31:0]       instr,
    output logic [CODE_W-1:0] code,
    output logic              illegal
);

    logic [5:0] opcode_s;
    logic [5:0] funct_s;

    assign opcode_s = instr[31:26];
    assign funct_s  = instr[5:0];

    // Table lookup: opcode first, funct only for the SPECIAL opcode
    always_comb begin
        code    = 31'd0;
        illegal = 1'b0;
        case (opcode_s)
            OP_SPECIAL: begin
                case (funct_s)
                    FN_ADD:  code = onehot_code(IDX_ADD);
                    FN_ADDU: code = onehot_code(IDX_ADDU);
                    FN_SUB:  code = onehot_code(IDX_SUB);
                    FN_SUBU: code = onehot_code(IDX_SUBU);
                    FN_AND:  code = onehot_code(IDX_AND);
                    FN_OR:   code = onehot_code(IDX_OR);
                    FN_XOR:  code = onehot_code(IDX_XOR);
                    FN_NOR:  code = onehot_code(IDX_NOR);
                    FN_SLT:  code = onehot_code(IDX_SLT);
                    FN_SLTU: code = onehot_code(IDX_SLTU);
                    FN_SLL:  code = onehot_code(IDX_SLL);
                    FN_SRL:  code = onehot_code(IDX_SRL);
                    FN_SRA:  code = onehot_code(IDX_SRA);
                    FN_SLLV: code = onehot_code(IDX_SLLV);
                    FN_SRLV: code = onehot_code(IDX_SRLV);
                    FN_SRAV: code = onehot_code(IDX_SRAV);
                    FN_JR:   code = onehot_code(IDX_JR);
                    default: illegal = 1'b1;
                endcase
            end
            OP_ADDI:  code = onehot_code(IDX_ADDI);
            OP_ADDIU: code = onehot_code(IDX_ADDIU);
            OP_ANDI:  code = onehot_code(IDX_ANDI);
            OP_ORI:   code = onehot_code(IDX_ORI);
            OP_XORI:  code = onehot_code(IDX_XORI);
            OP_LW:    code = onehot_code(IDX_LW);
            OP_SW:    code = onehot_code(IDX_SW);
            OP_BEQ:   code = onehot_code(IDX_BEQ);
            OP_BNE:   code = onehot_code(IDX_BNE);
            OP_SLTI:  code = onehot_code(IDX_SLTI);
            OP_SLTIU: code = onehot_code(IDX_SLTIU);
            OP_LUI:   code = onehot_code(IDX_LUI);
            OP_J:     code = onehot_code(IDX_J);
            OP_JAL:   code = onehot_code(IDX_JAL);
            default:  illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/instr_fetch_decode.sv
// Instruction fetch and decode stage.
// Accepts a PC from the PC stage, fetches the word from instruction memory
// with a bounded wait, decodes it into a one-hot operation vector and
// presents it to the controller until consumed. One instruction in flight.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   pc_in, pc_valid, pc_ready  fetch address handshake from the PC stage
//   im_req, im_addr            instruction-memory request and address
//   im_rdata, im_ack           instruction-memory data and acknowledge
//   code, instr, pc_out        decoded vector, raw word and its PC
//   code_valid, code_ready     handshake toward the controller
//   illegal                    presented word has no known encoding
//   fetch_err                  one-cycle pulse when a fetch timed out
module instr_fetch_decode
    import instr_fetch_decode_pkg::*;
#(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       pc_in,
    input  logic              pc_valid,
    output logic              pc_ready,
    output logic              im_req,
    output logic [31:0]       im_addr,
    input  logic [31:0]       im_rdata,
    input  logic              im_ack,
    output logic [CODE_W-1:0] code,
    output logic [31:0]       instr,
    output logic [31:0]       pc_out,
    output logic              code_valid,
    input  logic              code_ready,
    output logic              illegal,
    output logic              fetch_err
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
    // Abort on the edge that would take the counter to TIMEOUT, so FETCH
    // lasts exactly TIMEOUT cycles when no acknowledge arrives.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    fsm_state_e        state_q, state_d;
    logic [31:0]       pc_q, pc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       instr_q, instr_d;
    logic [CODE_W-1:0] code_q, code_d;
    logic              illegal_q, illegal_d;
    logic [31:0]       pc_out_q, pc_out_d;
    logic              fetch_err_q, fetch_err_d;

    logic [CODE_W-1:0] dec_code_s;
    logic              dec_illegal_s;

    // Decode straight off the memory bus so the result can be captured on ack
    instr_decode_rom u_rom (
        .instr   (im_rdata),
        .code    (dec_code_s),
        .illegal (dec_illegal_s)
    );

    // Next-state and datapath update logic
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        cnt_d       = cnt_q;
        instr_d     = instr_q;
        code_d      = code_q;
        illegal_d   = illegal_q;
        pc_out_d    = pc_out_q;
        fetch_err_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (pc_valid) begin
                    pc_d    = pc_in;
                    cnt_d   = '0;
                    state_d = FETCH;
                end else begin
                    state_d = IDLE;
                end
            end
            FETCH: begin
                if (im_ack) begin
                    instr_d   = im_rdata;
                    code_d    = dec_code_s;
                    illegal_d = dec_illegal_s;
                    pc_out_d  = pc_q;
                    cnt_d     = '0;
                    state_d   = HOLD;
                end else if (cnt_q == CNT_LAST) begin
                    fetch_err_d = 1'b1;
                    cnt_d       = '0;
                    state_d     = IDLE;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = FETCH;
                end
            end
            HOLD: begin
                if (code_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = HOLD;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath and status registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q        <= 32'd0;
            cnt_q       <= '0;
            instr_q     <= 32'd0;
            code_q      <= 31'd0;
            illegal_q   <= 1'b0;
            pc_out_q    <= 32'd0;
            fetch_err_q <= 1'b0;
        end else begin
            pc_q        <= pc_d;
            cnt_q       <= cnt_d;
            instr_q     <= instr_d;
            code_q      <= code_d;
            illegal_q   <= illegal_d;
            pc_out_q    <= pc_out_d;
            fetch_err_q <= fetch_err_d;
        end
    end

    // Handshake outputs are pure decodes of the state register
    assign pc_ready   = (state_q == IDLE);
    assign im_req     = (state_q == FETCH);
    assign code_valid = (state_q == HOLD);
    assign im_addr    = pc_q;
    assign code       = code_q;
    assign instr      = instr_q;
    assign pc_out     = pc_out_q;
    assign illegal    = illegal_q;
    assign fetch_err  = fetch_err_q;

endmodule

// File: tb/tb_instr_fetch_decode.sv
// Directed self-checking bench for instr_fetch_decode.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_instr_fetch_decode;

    logic        clk;
    logic        rst_n;
    logic [31:0] pc_in;
    logic        pc_valid;
    logic        pc_ready;
    logic        im_req;
    logic [31:0] im_addr;
    logic [31:0] im_rdata;
    logic        im_ack;
    logic [30:0] code;
    logic [31:0] instr;
    logic [31:0] pc_out;
    logic        code_valid;
    logic        code_ready;
    logic        illegal;
    logic        fetch_err;

    int n_chk;
    int n_fail;

    // Encodings of every legal operation, in code-bit order
    logic [5:0] fn_tab [0:16] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                                  6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h08};
    logic [5:0] op_tab [0:13] = '{6'h08, 6'h09, 6'h0C, 6'h0D, 6'h0E, 6'h23, 6'h2B,
                                  6'h04, 6'h05, 6'h0A, 6'h0B, 6'h0F, 6'h02, 6'h03};

    instr_fetch_decode #(.TIMEOUT(15)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pc_in      (pc_in),
        .pc_valid   (pc_valid),
        .pc_ready   (pc_ready),
        .im_req     (im_req),
        .im_addr    (im_addr),
        .im_rdata   (im_rdata),
        .im_ack     (im_ack),
        .code       (code),
        .instr      (instr),
        .pc_out     (pc_out),
        .code_valid (code_valid),
        .code_ready (code_ready),
        .illegal    (illegal),
        .fetch_err  (fetch_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present a PC for one cycle; returns at the falling edge inside FETCH
    task automatic issue(input logic [31:0] pc);
        @(negedge clk);
        pc_valid = 1'b1;
        pc_in    = pc;
        @(negedge clk);
        pc_valid = 1'b0;
    endtask

    // Acknowledge immediately; returns at the falling edge inside HOLD
    task automatic ack_now(input logic [31:0] data);
        im_ack   = 1'b1;
        im_rdata = data;
        @(negedge clk);
        im_ack   = 1'b0;
    endtask

    // Consume the presented code; returns at the falling edge back in IDLE
    task automatic consume();
        code_ready = 1'b1;
        @(negedge clk);
        code_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        n_chk++; if (code !== 31'd0) begin n_fail++; $display("FAIL reset_code: got %h exp 0", code); end
        n_chk++; if (instr !== 32'd0 || pc_out !== 32'd0) begin n_fail++; $display("FAIL reset_instr_pc: got %h %h exp 0 0", instr, pc_out); end
        n_chk++; if ({code_valid, im_req, illegal, fetch_err} !== 4'b0000) begin n_fail++; $display("FAIL reset_flags: got %b exp 0000", {code_valid, im_req, illegal, fetch_err}); end
        n_chk++; if (pc_ready !== 1'b1) begin n_fail++; $display("FAIL reset_pc_ready: got %b exp 1", pc_ready); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_add();
        issue(32'h0040_0000);
        n_chk++; if (im_req !== 1'b1 || im_addr !== 32'h0040_0000) begin n_fail++; $display("FAIL add_req: got req %b addr %h exp 1 00400000", im_req, im_addr); end
        n_chk++; if (pc_ready !== 1'b0 || code_valid !== 1'b0) begin n_fail++; $display("FAIL add_fetch_flags: got ready %b valid %b exp 0 0", pc_ready, code_valid); end
        ack_now(32'h012A_4020);
        n_chk++; if (code_valid !== 1'b1) begin n_fail++; $display("FAIL add_valid: got %b exp 1", code_valid); end
        n_chk++; if (code !== 31'h0000_0001) begin n_fail++; $display("FAIL add_code: got %h exp 00000001", code); end
        n_chk++; if (instr !== 32'h012A_4020 || pc_out !== 32'h0040_0000) begin n_fail++; $display("FAIL add_instr_pc: got %h %h exp 012a4020 00400000", instr, pc_out); end
        n_chk++; if (illegal !== 1'b0 || im_req !== 1'b0) begin n_fail++; $display("FAIL add_hold_flags: got ill %b req %b exp 0 0", illegal, im_req); end
        consume();
        n_chk++; if (code_valid !== 1'b0 || pc_ready !== 1'b1) begin n_fail++; $display("FAIL add_idle: got valid %b ready %b exp 0 1", code_valid, pc_ready); end
        n_chk++; if (code !== 31'h0000_0001 || instr !== 32'h012A_4020) begin n_fail++; $display("FAIL add_keep: got %h %h exp 00000001 012a4020", code, instr); end
    endtask

    task automatic test_lw_hold();
        issue(32'h0040_0004);
        ack_now(32'h8C88_0004);
        // Stall the controller and try to push another PC meanwhile
        pc_valid = 1'b1;
        pc_in    = 32'hDEAD_0000;
        for (int i = 0; i < 5; i++) begin
            n_chk++; if (code_valid !== 1'b1 || code !== (31'd1 << 22)) begin n_fail++; $display("FAIL lw_hold_%0d: got valid %b code %h exp 1 00400000", i, code_valid, code); end
            n_chk++; if (pc_ready !== 1'b0 || im_req !== 1'b0 || pc_out !== 32'h0040_0004) begin n_fail++; $display("FAIL lw_ignore_%0d: got ready %b req %b pc %h exp 0 0 00400004", i, pc_ready, im_req, pc_out); end
            @(negedge clk);
        end
        pc_valid = 1'b0;
        consume();
        n_chk++; if (code_valid !== 1'b0 || pc_ready !== 1'b1) begin n_fail++; $display("FAIL lw_release: got valid %b ready %b exp 0 1", code_valid, pc_ready); end
    endtask

    task automatic test_illegal();
        issue(32'h0040_0008);
        ack_now(32'hFC00_0000);
        n_chk++; if (code !== 31'd0 || illegal !== 1'b1 || code_valid !== 1'b1) begin n_fail++; $display("FAIL illegal: got code %h ill %b valid %b exp 0 1 1", code, illegal, code_valid); end
        consume();
        n_chk++; if (pc_ready !== 1'b1) begin n_fail++; $display("FAIL illegal_consumed: got ready %b exp 1", pc_ready); end
    endtask

    task automatic test_timeout();
        int req_cycles;
        req_cycles = 0;
        issue(32'h0040_000C);
        while (im_req === 1'b1 && req_cycles < 40) begin
            n_chk++; if (fetch_err !== 1'b0) begin n_fail++; $display("FAIL to_early_err: got %b exp 0 at cycle %0d", fetch_err, req_cycles); end
            req_cycles++;
            @(negedge clk);
        end
        n_chk++; if (req_cycles != 15) begin n_fail++; $display("FAIL to_cycles: got %0d exp 15", req_cycles); end
        n_chk++; if (fetch_err !== 1'b1 || im_req !== 1'b0 || pc_ready !== 1'b1 || code_valid !== 1'b0) begin n_fail++; $display("FAIL to_abort: got err %b req %b ready %b valid %b exp 1 0 1 0", fetch_err, im_req, pc_ready, code_valid); end
        @(negedge clk);
        n_chk++; if (fetch_err !== 1'b0) begin n_fail++; $display("FAIL to_pulse: got %b exp 0", fetch_err); end
    endtask

    task automatic test_reset_in_hold();
        issue(32'h0040_0010);
        ack_now(32'h012A_4020);
        n_chk++; if (code_valid !== 1'b1) begin n_fail++; $display("FAIL rh_hold: got %b exp 1", code_valid); end
        rst_n = 1'b0;
        #1;
        n_chk++; if (code_valid !== 1'b0 || code !== 31'd0 || instr !== 32'd0 || pc_out !== 32'd0 || pc_ready !== 1'b1) begin n_fail++; $display("FAIL rh_async: got valid %b code %h instr %h pc %h ready %b exp 0 0 0 0 1", code_valid, code, instr, pc_out, pc_ready); end
        @(negedge clk);
        im_ack   = 1'b1;
        im_rdata = 32'h8C88_0004;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        n_chk++; if (code_valid !== 1'b0 || im_req !== 1'b0 || code !== 31'd0 || instr !== 32'd0 || illegal !== 1'b0) begin n_fail++; $display("FAIL rh_late_ack: got valid %b req %b code %h instr %h ill %b exp 0 0 0 0 0", code_valid, im_req, code, instr, illegal); end
        im_ack = 1'b0;
    endtask

    task automatic test_sweep();
        logic [31:0] word;
        for (int i = 0; i < 31; i++) begin
            if (i < 17) word = {6'h00, 20'h12345, fn_tab[i]};
            else        word = {op_tab[i-17], 26'h0000123};
            issue(32'h0050_0000 + 32'(i * 4));
            ack_now(word);
            n_chk++; if (code !== (31'd1 << i) || $countones(code) != 1 || illegal !== 1'b0) begin n_fail++; $display("FAIL sweep_%0d: got code %h ill %b exp %h 0", i, code, illegal, 31'd1 << i); end
            consume();
        end
    endtask

    initial begin
        n_chk      = 0;
        n_fail     = 0;
        pc_in      = 32'd0;
        pc_valid   = 1'b0;
        im_rdata   = 32'd0;
        im_ack     = 1'b0;
        code_ready = 1'b0;
        test_reset();
        test_add();
        test_lw_hold();
        test_illegal();
        test_timeout();
        test_reset_in_hold();
        test_sweep();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_fetch_decode.md
INSTR_FETCH_DECODE -- requirements
Module: instr_fetch_decode

Interface
REQ-001 SHALL have parameter TIMEOUT, default 15: the maximum number of cycles to wait for im_ack before aborting a fetch.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have ports pc_in (input, 32 bits) and pc_valid (input, 1 bit): the fetch address and its valid flag from the PC stage.
REQ-005 SHALL have port pc_ready, output, 1 bit: high when the block accepts pc_in.
REQ-006 SHALL have ports im_req (output, 1), im_addr (output, 32), im_rdata (input, 32) and im_ack (input, 1): the instruction-memory request/acknowledge interface.
REQ-007 SHALL have ports code (output, 31 bits), instr (output, 32 bits) and pc_out (output, 32 bits): the one-hot operation vector, the raw instruction word and its PC, all sent to the controller.
REQ-008 SHALL have port code_valid (output, 1) and code_ready (input, 1): the handshake toward the controller.
REQ-009 SHALL have ports illegal (output, 1) and fetch_err (output, 1): status flags.

Function
REQ-010 SHALL implement a state machine with states IDLE, FETCH and HOLD.
REQ-011 In IDLE: pc_ready=1; on pc_valid, SHALL latch pc_in into the PC register and move to FETCH on the next cycle.
REQ-012 In FETCH: im_req=1 and im_addr=latched PC, held stable until im_ack; the timeout counter SHALL increment each cycle.
REQ-013 On im_ack in FETCH: SHALL register im_rdata into instr and its decode into code, clear the counter, and enter HOLD.
REQ-014 If the counter reaches TIMEOUT without im_ack: SHALL pulse fetch_err for 1 cycle, drop im_req, and return to IDLE with code_valid=0.
REQ-015 In HOLD: code_valid=1; code, instr, pc_out and illegal SHALL be held stable until code_ready=1, then the block goes to IDLE.
REQ-016 Load latency: an im_ack at edge N SHALL give code_valid=1 from edge N+1.
REQ-017 Throughput: pc_ready=1 only in IDLE, so at most one instruction is in flight; pc_valid in FETCH or HOLD is ignored.
REQ-018 Decode SHALL set exactly one code bit, with bit indices as follows:
  - ADD0 ADDU1 SUB2 SUBU3 AND4 OR5 XOR6 NOR7 SLT8 SLTU9 SLL10 SRL11 SRA12 SLLV13 SRLV14 SRAV15 JR16
  - ADDI17 ADDIU18 ANDI19 ORI20 XORI21 LW22 SW23 BEQ24 BNE25 SLTI26 SLTIU27 LUI28 J29 JAL30
REQ-019 When opcode=0, decode SHALL use funct:
  - 20h ADD, 21h ADDU, 22h SUB, 23h SUBU, 24h AND, 25h OR, 26h XOR, 27h NOR
  - 2Ah SLT, 2Bh SLTU, 00h SLL, 02h SRL, 03h SRA, 04h SLLV, 06h SRLV, 07h SRAV, 08h JR
REQ-020 Otherwise decode SHALL use opcode:
  - 08h ADDI, 09h ADDIU, 0Ch ANDI, 0Dh ORI, 0Eh XORI, 23h LW, 2Bh SW
  - 04h BEQ, 05h BNE, 0Ah SLTI, 0Bh SLTIU, 0Fh LUI, 02h J, 03h JAL
REQ-021 An unmatched encoding SHALL give code=0 and illegal=1, still be presented with code_valid=1, and be consumed normally.
REQ-022 Outside HOLD: code_valid=0, and code, instr and pc_out keep their last values.

Reset
REQ-023 Asserting rst_n=0 SHALL immediately force:
  - state=IDLE
  - code, instr, pc_out and the counter to 0
  - code_valid, im_req, illegal and fetch_err to 0
  - pc_ready=1
REQ-024 Reset mid-FETCH or mid-HOLD SHALL abandon the transaction; a late im_ack arriving after reset is ignored.

Structure
REQ-025 A shared package SHALL hold the opcode and funct constants, the 31 one-hot bit-index constants, and the state enum.
REQ-026 A combinational sub-module instr_decode_rom (instr in, code and illegal out) SHALL hold the decode table; the FSM, counter and registers stay in the top module.

Verification
REQ-027 Issue pc_in=0x00400000 with pc_valid=1 and an instant ack with im_rdata=0x012A4020 (add): im_addr=0x00400000, code=0x00000001, pc_out=0x00400000, code_valid=1 the cycle after ack.
REQ-028 Feed im_rdata=0x8C880004 (lw) while holding code_ready=0 for 5 cycles: code=1<<22 stays stable with code_valid=1; IDLE is re-entered the cycle after code_ready=1.
REQ-029 Feed im_rdata=0xFC000000: code=0, illegal=1, code_valid=1.
REQ-030 Never assert im_ack: fetch_err pulses 1 cycle after 15 FETCH cycles, then im_req=0 and pc_ready=1.
REQ-031 Assert rst_n=0 in HOLD, then send a late im_ack: all outputs reset, no code_valid.
REQ-032 Sweep all 31 legal encodings: popcount(code)=1 each time, with the index matching REQ-018.
